violation_reset_ctrl: RTL and testbench

// Downstream of the boundary monitor: turns its level "reset" request (and the CFA engine's

---
 rtl/violation_reset_ctrl.sv | 149 ++++++++++++++
 tb/tb_violation_reset_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/violation_reset_ctrl.sv
// violation_reset_ctrl
// Turns the level reset requests from the boundary monitor (bm_req) and the CFA
// engine (cf_req) into a fixed-width CPU reset pulse (puc_out). After each pulse it
// waits for the CPU to restart at RESET_HANDLER. It records a sticky violation cause
// and a saturating violation count for the TCB. Reaching MAX_VIOL violations holds
// the CPU in reset until power-on reset.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   bm_req        boundary monitor reset request (level)
//   cf_req        CFA engine reset request (level)
//   pc            current CPU program counter
//   cause_clr     TCB pulse that clears cause; honoured only in IDLE
//   puc_out       CPU reset request (registered)
//   cause         sticky cause, bit0 = boundary, bit1 = CFA
//   viol_cnt      saturating count of accepted violations
//   locked        high while in LOCK
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | CPU running, waiting for a request
// ASSERT   | puc_out held high while the pulse counter runs down
// WAIT_PC  | pulse done, waiting for pc == RESET_HANDLER (retry on timeout)
// LOCK     | violation limit reached, puc_out stuck high until rst_n
module violation_reset_ctrl #(
  parameter int unsigned PULSE_LEN     = 8,
  parameter logic [15:0] WAIT_MAX      = 16'h0100,
  parameter logic [7:0]  MAX_VIOL      = 8'hFF,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bm_req,
  input  logic        cf_req,
  input  logic [15:0] pc,
  input  logic        cause_clr,
  output logic        puc_out,
  output logic [1:0]  cause,
  output logic [7:0]  viol_cnt,
  output logic        locked
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_WAIT_PC = 2'd2,
    S_LOCK    = 2'd3
  } state_t;

  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);
  localparam logic [15:0] WAIT_LOAD  = WAIT_MAX - 16'd1;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  viol_cnt_q, viol_cnt_d;
  logic        puc_out_q, puc_out_d;
  logic        locked_q, locked_d;

  logic        req;
  logic [1:0]  req_bits;
  logic [7:0]  viol_inc;
  logic        accept;

  assign req      = bm_req | cf_req;
  assign req_bits = {cf_req, bm_req};
  assign viol_inc = (viol_cnt_q == 8'hFF) ? viol_cnt_q : viol_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    viol_cnt_d = viol_cnt_q;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
        end else if (cause_clr) begin
          cause_d = 2'b00;
        end
      end
      S_ASSERT: begin
        // Requests during the pulse are the same incident: record, don't count.
        cause_d = cause_q | req_bits;
        if (cnt_q == 16'd0) begin
          state_d = S_WAIT_PC;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_PC: begin
        if (req) begin
          accept = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'd0) begin
          // CPU did not restart in time: pulse again without counting.
          state_d = S_ASSERT;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_LOCK: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      viol_cnt_d = viol_inc;
      // A clear arriving with a request in IDLE drops the old cause; the new bits win.
      cause_d    = (((state_q == S_IDLE) && cause_clr) ? 2'b00 : cause_q) | req_bits;
      cnt_d      = PULSE_LOAD;
      state_d    = (viol_inc == MAX_VIOL) ? S_LOCK : S_ASSERT;
    end

    puc_out_d = (state_d == S_ASSERT) || (state_d == S_LOCK);
    locked_d  = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      cause_q    <= 2'b00;
      viol_cnt_q <= 8'd0;
      puc_out_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      viol_cnt_q <= viol_cnt_d;
      puc_out_q  <= puc_out_d;
      locked_q   <= locked_d;
    end
  end

  assign puc_out  = puc_out_q;
  assign cause    = cause_q;
  assign viol_cnt = viol_cnt_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// tb_violation_reset_ctrl
// Directed bench for violation_reset_ctrl with PULSE_LEN=4, WAIT_MAX=16, MAX_VIOL=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_violation_reset_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bm_req;
  logic        cf_req;
  logic [15:0] pc;
  logic        cause_clr;
  logic        puc_out;
  logic [1:0]  cause;
  logic [7:0]  viol_cnt;
  logic        locked;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  violation_reset_ctrl #(
    .PULSE_LEN    (4),
    .WAIT_MAX     (16'd16),
    .MAX_VIOL     (8'd3),
    .RESET_HANDLER(16'h0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bm_req   (bm_req),
    .cf_req   (cf_req),
    .pc       (pc),
    .cause_clr(cause_clr),
    .puc_out  (puc_out),
    .cause    (cause),
    .viol_cnt (viol_cnt),
    .locked   (locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bm_req = 1'b0; cf_req = 1'b0; cause_clr = 1'b0; pc = 16'h1234;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bm_req = 1'b0; cf_req = 1'b0; cause_clr = 1'b0; pc = 16'h1234;
    tick();
    tests++;
    if ({puc_out, cause, viol_cnt, locked} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs: got puc=%b cause=%b cnt=%0d locked=%b, want all 0",
               puc_out, cause, viol_cnt, locked);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    tests++;
    if (puc_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_puc: got %b want 0", puc_out);
    end
  endtask

  task automatic test_single_pulse();
    int width;
    int highs;
    do_reset();
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    tests++;
    if (puc_out !== 1'b1 || cause !== 2'b01 || viol_cnt !== 8'd1) begin
      fails++;
      $display("FAIL single_first: got puc=%b cause=%b cnt=%0d, want 1 01 1", puc_out, cause, viol_cnt);
    end
    width = 0;
    while (puc_out === 1'b1 && width < 20) begin
      width++;
      tick();
    end
    tests++;
    if (width != 4) begin
      fails++;
      $display("FAIL single_width: got %0d want 4", width);
    end
    pc = 16'h0000;
    tick();
    pc = 16'h1234;
    highs = 0;
    repeat (20) begin
      tick();
      if (puc_out === 1'b1) highs++;
    end
    tests++;
    if (highs != 0 || viol_cnt !== 8'd1) begin
      fails++;
      $display("FAIL single_back_idle: got %0d high cycles cnt=%0d, want 0 and 1", highs, viol_cnt);
    end
  endtask

  task automatic test_cause_merge();
    int width;
    do_reset();
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    cf_req = 1'b1;
    tick();
    cf_req = 1'b0;
    tests++;
    if (cause !== 2'b11 || viol_cnt !== 8'd1) begin
      fails++;
      $display("FAIL merge_cause: got cause=%b cnt=%0d, want 11 1", cause, viol_cnt);
    end
    width = 1;
    while (puc_out === 1'b1 && width < 20) begin
      width++;
      tick();
    end
    tests++;
    if (width != 4 || viol_cnt !== 8'd1) begin
      fails++;
      $display("FAIL merge_width: got width=%0d cnt=%0d, want 4 1", width, viol_cnt);
    end
  endtask

  task automatic test_retry();
    int width;
    int low;
    do_reset();
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    width = 0;
    while (puc_out === 1'b1 && width < 20) begin
      width++;
      tick();
    end
    low = 0;
    while (puc_out === 1'b0 && low < 40) begin
      low++;
      tick();
    end
    tests++;
    if (width != 4 || low != 16) begin
      fails++;
      $display("FAIL retry_gap: got width=%0d gap=%0d, want 4 16", width, low);
    end
    width = 0;
    while (puc_out === 1'b1 && width < 20) begin
      width++;
      tick();
    end
    tests++;
    if (width != 4 || viol_cnt !== 8'd1 || cause !== 2'b01) begin
      fails++;
      $display("FAIL retry_second: got width=%0d cnt=%0d cause=%b, want 4 1 01", width, viol_cnt, cause);
    end
  endtask

  task automatic test_lock();
    do_reset();
    pc = 16'h0000;
    for (int v = 1; v <= 2; v++) begin
      bm_req = 1'b1;
      tick();
      bm_req = 1'b0;
      tests++;
      if (viol_cnt !== 8'(v) || locked !== 1'b0 || puc_out !== 1'b1) begin
        fails++;
        $display("FAIL lock_pre%0d: got cnt=%0d locked=%b puc=%b, want %0d 0 1", v, viol_cnt, locked, puc_out, v);
      end
      repeat (6) tick();
    end
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    tests++;
    if (locked !== 1'b1 || puc_out !== 1'b1 || viol_cnt !== 8'd3) begin
      fails++;
      $display("FAIL lock_enter: got locked=%b puc=%b cnt=%0d, want 1 1 3", locked, puc_out, viol_cnt);
    end
    repeat (5) tick();
    bm_req = 1'b1; cf_req = 1'b1;
    repeat (3) tick();
    bm_req = 1'b0; cf_req = 1'b0;
    repeat (25) tick();
    tests++;
    if (locked !== 1'b1 || puc_out !== 1'b1 || viol_cnt !== 8'd3 || cause !== 2'b01) begin
      fails++;
      $display("FAIL lock_hold: got locked=%b puc=%b cnt=%0d cause=%b, want 1 1 3 01",
               locked, puc_out, viol_cnt, cause);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({puc_out, cause, viol_cnt, locked} !== 12'd0) begin
      fails++;
      $display("FAIL lock_reset: got puc=%b cause=%b cnt=%0d locked=%b, want all 0",
               puc_out, cause, viol_cnt, locked);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cause_clr();
    do_reset();
    pc = 16'h0000;
    cf_req = 1'b1;
    tick();
    cf_req = 1'b0;
    repeat (6) tick();
    tests++;
    if (cause !== 2'b10) begin
      fails++;
      $display("FAIL clr_setup: got cause=%b want 10", cause);
    end
    cause_clr = 1'b1; bm_req = 1'b1;
    tick();
    cause_clr = 1'b0; bm_req = 1'b0;
    tests++;
    if (cause !== 2'b01 || viol_cnt !== 8'd2 || puc_out !== 1'b1) begin
      fails++;
      $display("FAIL clr_with_req: got cause=%b cnt=%0d puc=%b, want 01 2 1", cause, viol_cnt, puc_out);
    end
    repeat (6) tick();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    tests++;
    if (cause !== 2'b00) begin
      fails++;
      $display("FAIL clr_idle: got cause=%b want 00", cause);
    end
    do_reset();
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    tests++;
    if (cause !== 2'b01 || puc_out !== 1'b1) begin
      fails++;
      $display("FAIL clr_in_assert: got cause=%b puc=%b, want 01 1", cause, puc_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (puc_out !== 1'b0 || viol_cnt !== 8'd0 || cause !== 2'b00) begin
      fails++;
      $display("FAIL async_mid_assert: got puc=%b cnt=%0d cause=%b, want 0 0 00", puc_out, viol_cnt, cause);
    end
    #1 rst_n = 1'b1;
    repeat (8) tick();
    tests++;
    if (puc_out !== 1'b0) begin
      fails++;
      $display("FAIL async_idle_after: got puc=%b want 0", puc_out);
    end
    bm_req = 1'b1;
    tick();
    bm_req = 1'b0;
    tests++;
    if (puc_out !== 1'b1 || viol_cnt !== 8'd1) begin
      fails++;
      $display("FAIL async_restart: got puc=%b cnt=%0d, want 1 1", puc_out, viol_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_cause_merge();
    test_retry();
    test_lock();
    test_cause_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
